relm_ps2_ctrl: RTL

RELM_PS2_CTRL -- requirements
Module: relm_ps2_ctrl

---
 rtl/relm_ps2_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/relm_ps2_ctrl.sv
// PS/2 host controller: glitch-filtered receive into a 4-entry FIFO and
// host-to-device byte transmit with inhibit, ACK check and frame timeout.
module relm_ps2_ctrl #(
    parameter int WD   = 32,
    parameter int FILT = 8,
    parameter int INH  = 5000,
    parameter int TMO  = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe_out,
    output logic          ps2_dat_oe_out,
    input  logic [WD:0]   push_d,
    output logic          push_retry,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q
);

    localparam int CMAX = (INH > TMO) ? INH : TMO;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RX      = 3'd1;
    localparam logic [2:0] TX_INH  = 3'd2;
    localparam logic [2:0] TX_BITS = 3'd3;
    localparam logic [2:0] TX_ACK  = 3'd4;
    localparam logic [2:0] TX_END  = 3'd5;

    // Line filters: index 0 is the clock line, index 1 the data line.
    logic [1:0] raw_lvl;
    logic [1:0] filt_lvl;
    logic [1:0] filt_lvl_next;

    assign raw_lvl = {ps2_dat_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic [FILT-1:0] sh_reg;
            logic            lvl_reg;
            logic            lvl_next;

            always_comb begin
                lvl_next = lvl_reg;
                if (&sh_reg)
                    lvl_next = 1'b1;
                else if (~|sh_reg)
                    lvl_next = 1'b0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh_reg  <= '1;
                    lvl_reg <= 1'b1;
                end else begin
                    sh_reg  <= {sh_reg[FILT-2:0], raw_lvl[gi]};
                    lvl_reg <= lvl_next;
                end
            end

            assign filt_lvl[gi]      = lvl_reg;
            assign filt_lvl_next[gi] = lvl_next;
        end
    endgenerate

    logic clk_f;
    logic dat_f;
    logic fall_reg;

    assign clk_f = filt_lvl[0];
    assign dat_f = filt_lvl[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fall_reg <= 1'b0;
        else
            fall_reg <= clk_f & ~filt_lvl_next[0];
    end

    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    rx_sh_reg;
    logic          par_reg;
    logic [8:0]    tx_reg;
    logic          clk_oe_reg;
    logic          dat_oe_reg;
    logic          ferr_reg;
    logic          ovr_reg;
    logic          nack_reg;
    logic [2:0]    wr_ptr_reg;
    logic [2:0]    rd_ptr_reg;
    logic [7:0]    fifo_mem [4];

    logic       push_stb;
    logic       pop_stb;
    logic [3:0] bit_next;
    logic       frame_end;
    logic       frame_good;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_do;
    logic       wr_do;
    logic       ovr_set;
    logic       ferr_set;
    logic       timed;
    logic       tmo_hit;
    logic       nack_set;

    assign push_stb   = push_d[WD];
    assign pop_stb    = pop_d[WD];
    assign bit_next   = bit_cnt_reg + 4'd1;
    assign frame_end  = (state_reg == RX) && fall_reg && (bit_cnt_reg == 4'd10);
    // Odd parity over data+parity, and a high stop bit sampled on this fall.
    assign frame_good = frame_end && (^{rx_sh_reg, par_reg}) && dat_f;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[2] != rd_ptr_reg[2]) &&
                        (wr_ptr_reg[1:0] == rd_ptr_reg[1:0]);
    assign pop_do     = pop_stb && !fifo_empty;
    assign wr_do      = frame_good && (!fifo_full || pop_do);
    assign ovr_set    = frame_good && fifo_full && !pop_do;
    assign ferr_set   = frame_end && !frame_good;
    assign timed      = (state_reg == RX) || (state_reg == TX_BITS) ||
                        (state_reg == TX_ACK) || (state_reg == TX_END);
    assign tmo_hit    = timed && !fall_reg && (cnt_reg == CW'(TMO - 1));
    assign nack_set   = (tmo_hit && (state_reg != RX)) ||
                        ((state_reg == TX_ACK) && fall_reg && dat_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            rx_sh_reg   <= '0;
            par_reg     <= 1'b0;
            tx_reg      <= '0;
            clk_oe_reg  <= 1'b0;
            dat_oe_reg  <= 1'b0;
        end else if (tmo_hit) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            clk_oe_reg <= 1'b0;
            dat_oe_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    // A push outranks a start bit arriving on the same cycle.
                    if (push_stb) begin
                        tx_reg      <= {~^push_d[7:0], push_d[7:0]};
                        clk_oe_reg  <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= TX_INH;
                    end else if (fall_reg && !dat_f) begin
                        bit_cnt_reg <= 4'd1;
                        state_reg   <= RX;
                    end
                end
                RX: begin
                    if (fall_reg) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= bit_next;
                        if (bit_cnt_reg <= 4'd8)
                            rx_sh_reg <= {dat_f, rx_sh_reg[7:1]};
                        else if (bit_cnt_reg == 4'd9)
                            par_reg <= dat_f;
                        else
                            state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_INH: begin
                    if (cnt_reg == CW'(INH - 1)) begin
                        cnt_reg    <= '0;
                        clk_oe_reg <= 1'b0;
                        dat_oe_reg <= 1'b1;
                        state_reg  <= TX_BITS;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_BITS: begin
                    if (fall_reg) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= bit_next;
                        if (bit_cnt_reg <= 4'd8) begin
                            dat_oe_reg <= ~tx_reg[bit_cnt_reg];
                        end else begin
                            dat_oe_reg <= 1'b0;
                            state_reg  <= TX_ACK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_ACK: begin
                    if (fall_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= TX_END;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TX_END: begin
                    if (clk_f && dat_f) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (fall_reg) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set on the same cycle as a pop is kept, not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_reg   <= 1'b0;
            ovr_reg    <= 1'b0;
            nack_reg   <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            ferr_reg <= ferr_set | (ferr_reg & ~pop_stb);
            ovr_reg  <= ovr_set  | (ovr_reg  & ~pop_stb);
            nack_reg <= nack_set | (nack_reg & ~pop_stb);
            if (wr_do)
                wr_ptr_reg <= wr_ptr_reg + 3'd1;
            if (pop_do)
                rd_ptr_reg <= rd_ptr_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do)
            fifo_mem[wr_ptr_reg[1:0]] <= rx_sh_reg;
    end

    logic unused_bits;
    assign unused_bits = ^{push_d[WD-1:8], pop_d[WD-1:0]};

    assign ps2_clk_oe_out = clk_oe_reg;
    assign ps2_dat_oe_out = dat_oe_reg;
    assign push_retry     = (state_reg != IDLE);
    assign pop_q          = {fifo_empty, {(WD-11){1'b0}}, nack_reg, ovr_reg,
                             ferr_reg, fifo_mem[rd_ptr_reg[1:0]]};

endmodule
